// File: rtl/bcd_pkg.sv
// Shared BCD helpers for seven-segment display blocks: segment decode and
// single-digit increment/decrement with carry/borrow.
package bcd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Returns {carry, digit}
    function automatic logic [4:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
    endfunction

    // Returns {borrow, digit}
    function automatic logic [4:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0) ? {1'b1, 4'd9} : {1'b0, d - 4'd1};
    endfunction

    function automatic logic [3:0] bcd_filter(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_mux_if.sv
// Control/data bundle of the BCD up/down counter with multiplexed 7-seg output.
interface bcd_updown_counter_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic                      up;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_val;
    logic [4*NUM_DIGITS-1:0]   count;
    logic                      wrap;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     an;

    modport master (
        output en, up, load, load_val,
        input  count, wrap, seg, an
    );

    modport slave (
        input  en, up, load, load_val,
        output count, wrap, seg, an
    );
endinterface

// File: rtl/bcd_seg_decoder.sv
// Combinational 7-segment decoder for one BCD digit with optional blanking.
module bcd_seg_decoder
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = blank_i ? SEG_BLANK : seg_decode(digit_i);
    end
endmodule

// File: rtl/bcd_updown_counter_mux.sv
// N-digit BCD up/down counter with load, step prescaler and a time-multiplexed
// active-low 7-segment driver.
module bcd_updown_counter_mux
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int SCAN_DIV   = 50_000,
    parameter bit BLANK_LZ   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    bcd_updown_counter_mux_if.slave   bus
);
    localparam int CW = 4 * NUM_DIGITS;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]         scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic                  tick;
    logic                  step_wrap;
    logic [CW-1:0]         step_val;
    logic [CW-1:0]         load_filt;
    logic [NUM_DIGITS-1:0] lz;
    logic [3:0]            cur_digit;
    logic                  cur_blank;
    dir_e                  dir;

    assign dir  = dir_e'(bus.up);
    assign tick = (tick_cnt_q == TICK_LAST);

    // Carry/borrow ripples from digit 0 upward; a carry out of the top digit is the wrap.
    always_comb begin : step_calc
        logic       carry;
        logic [4:0] res;
        carry     = 1'b1;
        res       = '0;
        step_val  = count_q;
        load_filt = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            res = (dir == DIR_UP) ? bcd_inc(count_q[4*i +: 4]) : bcd_dec(count_q[4*i +: 4]);
            if (carry) begin
                step_val[4*i +: 4] = res[3:0];
            end
            carry = carry & res[4];
            load_filt[4*i +: 4] = bcd_filter(bus.load_val[4*i +: 4]);
        end
        step_wrap = carry;
    end

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        count_d    = count_q;
        wrap_d     = 1'b0;
        if (bus.load) begin
            tick_cnt_d = '0;
            count_d    = load_filt;
        end else if (tick && bus.en) begin
            count_d = step_val;
            wrap_d  = step_wrap;
        end
    end

    always_comb begin
        scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end
    end

    // lz[i] is set when digit i and every digit above it are zero.
    always_comb begin : lz_calc
        logic        zero_run;
        int unsigned idx;
        zero_run = 1'b1;
        lz       = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            idx      = NUM_DIGITS - 1 - k;
            zero_run = zero_run & (count_q[4*idx +: 4] == 4'd0);
            lz[idx]  = zero_run;
        end
    end

    always_comb begin
        cur_digit = count_q[{scan_idx_q, 2'b00} +: 4];
        cur_blank = BLANK_LZ && (scan_idx_q != '0) && lz[scan_idx_q];
        an_d      = ~(NUM_DIGITS'(1) << scan_idx_q);
    end

    bcd_seg_decoder u_dec (
        .digit_i (cur_digit),
        .blank_i (cur_blank),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            an_q       <= ~NUM_DIGITS'(1);
            seg_q      <= SEG_ZERO;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.an    = an_q;
    assign bus.seg   = seg_q;

endmodule

// File: tb/tb_bcd_updown_counter_mux.sv
// Scoreboard bench: two counters (leading zeros shown / blanked) on shared stimulus,
// checked every cycle against a decimal-arithmetic reference.
module tb_bcd_updown_counter_mux;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bcd_updown_counter_mux_if #(.NUM_DIGITS(ND)) bus0 ();
    bcd_updown_counter_mux_if #(.NUM_DIGITS(ND)) bus1 ();

    assign bus1.en       = bus0.en;
    assign bus1.up       = bus0.up;
    assign bus1.load     = bus0.load;
    assign bus1.load_val = bus0.load_val;

    bcd_updown_counter_mux #(.NUM_DIGITS(ND), .TICK_DIV(1), .SCAN_DIV(2), .BLANK_LZ(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    bcd_updown_counter_mux #(.NUM_DIGITS(ND), .TICK_DIV(1), .SCAN_DIV(2), .BLANK_LZ(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        string      tag;
        logic [15:0] cnt;
        logic        wrap;
        logic [3:0]  an;
        logic [6:0]  seg0;
        logic [6:0]  seg1;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int v      = 0;
    int m_idx  = 0;
    int m_scnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic int pow10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int x);
        logic [15:0] r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((x / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int filt(input logic [15:0] lv);
        int r = 0;
        for (int i = 0; i < ND; i++) begin
            if (lv[4*i +: 4] <= 4'd9) r = r + int'(lv[4*i +: 4]) * pow10(i);
        end
        return r;
    endfunction

    function automatic logic [6:0] dec7(input int d);
        logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    task automatic step(input string tag, input logic e, input logic u, input logic l,
                        input logic [15:0] lv);
        exp_t x;
        int   d;
        bus0.en       = e;
        bus0.up       = u;
        bus0.load     = l;
        bus0.load_val = lv;
        d      = (v / pow10(m_idx)) % 10;
        x.tag  = tag;
        x.an   = ~(4'b0001 << m_idx);
        x.seg0 = dec7(d);
        x.seg1 = (m_idx != 0 && v < pow10(m_idx)) ? 7'b1111111 : dec7(d);
        x.wrap = 1'b0;
        if (l) begin
            v = filt(lv);
        end else if (e && u) begin
            x.wrap = (v == 9999);
            v = (v + 1) % 10000;
        end else if (e) begin
            x.wrap = (v == 0);
            v = (v + 9999) % 10000;
        end
        x.cnt = to_bcd(v);
        if (m_scnt == 1) begin
            m_scnt = 0;
            m_idx  = (m_idx + 1) % ND;
        end else begin
            m_scnt++;
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_eq({x.tag, ".count"},  32'(bus0.count), 32'(x.cnt));
        check_eq({x.tag, ".wrap"},   32'(bus0.wrap),  32'(x.wrap));
        check_eq({x.tag, ".an"},     32'(bus0.an),    32'(x.an));
        check_eq({x.tag, ".seg"},    32'(bus0.seg),   32'(x.seg0));
        check_eq({x.tag, ".count_b"},32'(bus1.count), 32'(x.cnt));
        check_eq({x.tag, ".an_b"},   32'(bus1.an),    32'(x.an));
        check_eq({x.tag, ".seg_b"},  32'(bus1.seg),   32'(x.seg1));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".count"}, 32'(bus0.count), 32'h0000);
        check_eq({tag, ".wrap"},  32'(bus0.wrap),  32'h0);
        check_eq({tag, ".an"},    32'(bus0.an),    32'b1110);
        check_eq({tag, ".seg"},   32'(bus0.seg),   32'b1000000);
        check_eq({tag, ".seg_b"}, 32'(bus1.seg),   32'b1000000);
    endtask

    initial begin
        bus0.en       = 1'b0;
        bus0.up       = 1'b1;
        bus0.load     = 1'b0;
        bus0.load_val = '0;
        #2 rst = 1'b1;
        #1 check_reset_state("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of counting
        step("mid_load", 1'b0, 1'b1, 1'b1, 16'h0355);
        step("mid_up",   1'b1, 1'b1, 1'b0, 16'h0000);
        step("mid_up",   1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("mid_pre.count", 32'(bus0.count), 32'h0357);
        rst = 1'b1;
        #1 check_reset_state("mid_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        v = 0; m_idx = 0; m_scnt = 0;

        step("upw_load", 1'b1, 1'b1, 1'b1, 16'h9998);
        for (int i = 0; i < 3; i++) step("upw", 1'b1, 1'b1, 1'b0, 16'h0000);

        step("dnw_load", 1'b1, 1'b0, 1'b1, 16'h0001);
        for (int i = 0; i < 3; i++) step("dnw", 1'b1, 1'b0, 1'b0, 16'h0000);

        step("filt", 1'b1, 1'b1, 1'b1, 16'h12A4);
        check_eq("filt_abs.count", 32'(bus0.count), 32'h1204);

        step("gate_load", 1'b0, 1'b1, 1'b1, 16'h0042);
        for (int i = 0; i < 10; i++) step("gate", 1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'h0000);

        step("scan_load", 1'b0, 1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 10; i++) step("scan", 1'b0, 1'b1, 1'b0, 16'h0000);

        step("blank_load", 1'b0, 1'b1, 1'b1, 16'h0007);
        for (int i = 0; i < 10; i++) step("blank", 1'b0, 1'b1, 1'b0, 16'h0000);

        for (int i = 0; i < 60; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end
endmodule
